nibble_add_seq: RTL and testbench

Sequencer that computes a multi-nibble add or subtract by driving one shared 4-bit adder slice serially, least-significant nibble first. It sits between a requester with a start/ready/done handshake and the nibble-adder datapath. It trades latency for area: one slice, NIBBLES cycles per operation. It reports the result, the unsigned carry-out and the signed overflow.

---
 rtl/adder_pkg.sv | 19 +
 rtl/nibble_adder.sv | 29 ++
 rtl/nibble_add_seq.sv | 170 +++++++++++++++++
 tb/tb_nibble_add_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the serial nibble add/subtract sequencer.
package adder_pkg;

    // Width of the single adder slice that is reused every RUN cycle.
    localparam int NIB_W = 4;

    // Sequencer states. The unused encoding 2'd3 recovers to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The nibble index always needs at least one bit, even for a one-nibble operand.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// One 4-bit ripple adder slice.
// It also exposes the carry into bit 3 so that signed overflow can be
// formed on the most-significant slice.
module nibble_adder
    import adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             c3
);

    // Lower three bits: w_low[3] is the carry into bit 3.
    logic [3:0] w_low;
    // Top bit: w_high[1] is the slice carry-out.
    logic [1:0] w_high;

    // Split the add at bit 3 so the internal carry is visible.
    always_comb begin
        w_low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
        w_high = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, w_low[3]};
        s      = {w_high[0], w_low[2:0]};
        cout   = w_high[1];
        c3     = w_low[3];
    end

endmodule

// File: rtl/nibble_add_seq.sv
// Serial multi-nibble add/subtract sequencer.
// It drives one shared 4-bit adder slice, least-significant nibble first,
// and takes NIBBLES cycles per operation.
// The handshake is start/ready/done. The results are sum, carry-out and
// signed overflow.
module nibble_add_seq
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sub,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     carry,
    output logic                     overflow
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t            r_state;
    state_t            w_next_state;

    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_sub;
    logic [IDX_W-1:0]  r_idx;
    logic              r_c;
    logic [W-1:0]      r_sum;
    logic              r_carry;
    logic              r_ovf;

    logic              w_accept;
    logic              w_run;
    logic              w_last;
    logic [NIB_W-1:0]  w_a_nib;
    logic [NIB_W-1:0]  w_b_nib;
    logic [NIB_W-1:0]  w_b_op;
    logic [NIB_W-1:0]  w_s;
    logic              w_co;
    logic              w_c3;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = (r_idx == LAST_IDX);

    // Select the current operand nibbles from the latched operands.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_nib = r_a[i*NIB_W +: NIB_W];
                w_b_nib = r_b[i*NIB_W +: NIB_W];
            end
        end
    end

    // Subtraction is a + ~b + 1. The +1 comes from the initial carry.
    assign w_b_op = w_b_nib ^ {NIB_W{r_sub}};

    nibble_adder u_slice (
        .a    (w_a_nib),
        .b    (w_b_op),
        .cin  (r_c),
        .s    (w_s),
        .cout (w_co),
        .c3   (w_c3)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and Moore handshake outputs.
    always_comb begin
        w_next_state = S_IDLE;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready        = 1'b1;
                w_next_state = start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                busy         = 1'b1;
                w_next_state = w_last ? S_DONE : S_RUN;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Capture the operands on accept. Later changes to a, b and sub are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sub <= sub;
        end
    end

    // Nibble index and ripple carry.
    // The index returns to 0 after the last nibble, which keeps it in range
    // when NIBBLES is not a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_c   <= 1'b0;
        end else if (w_accept) begin
            r_idx <= '0;
            r_c   <= sub;
        end else if (w_run) begin
            r_c   <= w_co;
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Write each slice result into its nibble of the sum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_run) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_sum[i*NIB_W +: NIB_W] <= w_s;
                end
            end
        end
    end

    // Carry and signed overflow come from the most-significant slice only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_run && w_last) begin
            r_carry <= w_co;
            r_ovf   <= w_c3 ^ w_co;
        end
    end

    assign sum      = r_sum;
    assign carry    = r_carry;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq.
// A vector table covers the arithmetic cases. Hand-written sequences cover
// the handshake and reset corner cases, plus a NIBBLES=1 instance.
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sub;
    logic [15:0] a, b;
    logic        ready, busy, done;
    logic [15:0] sum;
    logic        carry, overflow;

    logic        s1_start, s1_sub;
    logic [3:0]  s1_a, s1_b, s1_sum;
    logic        s1_ready, s1_busy, s1_done, s1_carry, s1_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_add_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .sum(sum),
        .carry(carry), .overflow(overflow)
    );

    nibble_add_seq #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .a(s1_a), .b(s1_b),
        .ready(s1_ready), .busy(s1_busy), .done(s1_done), .sum(s1_sum),
        .carry(s1_carry), .overflow(s1_ovf)
    );

    typedef struct packed {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];
    vec_t bb   [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for ready and issues one operation.
    // Then watches 9 cycles after the accept edge and scrambles the operands
    // after sampling.
    task automatic run_op(input logic s, input logic [15:0] va, input logic [15:0] vb,
                          output int lat, output int bcnt, output int dcnt);
        int guard;
        guard = 0;
        while (!ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_start", ready, 1);
        start = 1'b1; sub = s; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; a = ~va; b = ~vb; sub = ~s;
        lat = -1; bcnt = 0; dcnt = 0;
        for (int k = 0; k <= 8; k++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) lat = k;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, bcnt, dcnt, nacc, ndone, last_acc;
        logic prev_ready;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0};

        bb[0] = '{1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0};
        bb[1] = '{1'b0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0};
        bb[2] = '{1'b1, 16'h0003, 16'h0001, 16'h0002, 1'b1, 1'b0};
        bb[3] = '{1'b0, 16'hF000, 16'h2000, 16'h1000, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        s1_start = 1'b0; s1_sub = 1'b0; s1_a = '0; s1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 16'h0000);
        check("rst_carry", carry, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of arithmetic vectors.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat, bcnt, dcnt);
            check($sformatf("v%0d_latency", i), lat, 4);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 4);
            check($sformatf("v%0d_done_pulses", i), dcnt, 1);
            check($sformatf("v%0d_sum", i), sum, vecs[i].sum);
            check($sformatf("v%0d_carry", i), carry, vecs[i].carry);
            check($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
        end

        // A start held during RUN, with operands changing, is ignored until ready.
        start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
        @(posedge clk); #1;
        sub = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        dcnt = 0; nacc = -1; prev_ready = ready;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (prev_ready && start && nacc < 0) begin
                nacc = k;
                start = 1'b0;
            end
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin
                    check("midrun_done_time", k, 4);
                    check("midrun_sum", sum, 16'h3333);
                    check("midrun_carry", carry, 0);
                    check("midrun_ovf", overflow, 0);
                end else begin
                    check("second_done_time", k, 10);
                    check("second_sum", sum, 16'h0000);
                    check("second_carry", carry, 1);
                end
            end
            if (k == 6) check("midrun_single_done", dcnt, 1);
            prev_ready = ready;
        end
        check("midrun_next_accept", nacc, 6);
        check("midrun_total_dones", dcnt, 2);

        // Asynchronous reset two cycles into RUN aborts the operation.
        start = 1'b1; sub = 1'b0; a = 16'hAAAA; b = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_abort_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 16'h0000);
        check("abort_carry", carry, 0);
        check("abort_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        run_op(1'b0, 16'h0001, 16'h0001, lat, bcnt, dcnt);
        check("post_abort_sum", sum, 16'h0002);
        check("post_abort_latency", lat, 4);

        // Back-to-back: start held high, operands reloaded after each accept.
        start = 1'b1; sub = bb[0].sub; a = bb[0].a; b = bb[0].b;
        nacc = 0; ndone = 0; last_acc = -1; prev_ready = ready;
        for (int k = 1; k <= 40 && ndone < 4; k++) begin
            @(posedge clk); #1;
            if (prev_ready && start) begin
                if (nacc > 0) check("b2b_interval", k - last_acc, 6);
                last_acc = k;
                nacc++;
                if (nacc < 4) begin
                    sub = bb[nacc].sub; a = bb[nacc].a; b = bb[nacc].b;
                end else begin
                    start = 1'b0;
                end
            end
            if (done) begin
                check($sformatf("b2b%0d_sum", ndone), sum, bb[ndone].sum);
                check($sformatf("b2b%0d_carry", ndone), carry, bb[ndone].carry);
                check($sformatf("b2b%0d_ovf", ndone), overflow, bb[ndone].ovf);
                ndone++;
            end
            prev_ready = ready;
        end
        start = 1'b0;
        check("b2b_dones", ndone, 4);

        // NIBBLES=1 instance: one RUN cycle, done one cycle after the accept edge.
        for (int t = 0; t < 2; t++) begin
            logic [3:0] ea, eb, es;
            logic       esub, ec, ev;
            if (t == 0) begin esub = 1'b0; ea = 4'hF; eb = 4'h1; es = 4'h0; ec = 1'b1; ev = 1'b0; end
            else        begin esub = 1'b1; ea = 4'h8; eb = 4'h1; es = 4'h7; ec = 1'b1; ev = 1'b1; end
            s1_start = 1'b1; s1_sub = esub; s1_a = ea; s1_b = eb;
            @(posedge clk); #1;
            s1_start = 1'b0; s1_a = ~ea; s1_b = ~eb;
            lat = -1;
            for (int k = 0; k <= 4; k++) begin
                if (s1_done && lat < 0) lat = k;
                @(posedge clk); #1;
            end
            check($sformatf("n1_t%0d_latency", t), lat, 1);
            check($sformatf("n1_t%0d_sum", t), s1_sum, es);
            check($sformatf("n1_t%0d_carry", t), s1_carry, ec);
            check($sformatf("n1_t%0d_ovf", t), s1_ovf, ev);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
